// File: rtl/dac_update_sched.sv
// dac_update_sched: shares one multicycle DAC conversion datapath among N_CH
// channels. Requests and calibration writes mark a channel pending. Pending
// channels are issued round-robin to the converter. The result is captured
// into the channel's DAC register together with a one-cycle update strobe.
module dac_update_sched #(
    parameter int FLOAT_WIDTH = 64,
    parameter int INT_WIDTH   = 16,
    parameter int DAC_WIDTH   = 14,
    parameter int N_CH        = 4,
    parameter int CONV_LAT    = 2,
    localparam int CH_W       = $clog2(N_CH)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ENABLE,
    input  logic                      REQ_VALID,
    input  logic [CH_W-1:0]           REQ_CH,
    input  logic [FLOAT_WIDTH-1:0]    REQ_VOLTAGE,
    output logic                      REQ_READY,
    input  logic                      CAL_WE,
    input  logic [CH_W-1:0]           CAL_CH,
    input  logic [FLOAT_WIDTH-1:0]    CAL_GAIN,
    input  logic [FLOAT_WIDTH-1:0]    CAL_OFFSET,
    output logic [FLOAT_WIDTH-1:0]    CONV_VOLTAGE,
    output logic [FLOAT_WIDTH-1:0]    CONV_GAIN,
    output logic [FLOAT_WIDTH-1:0]    CONV_OFFSET,
    input  logic [DAC_WIDTH-1:0]      CONV_CODE,
    output logic [N_CH*DAC_WIDTH-1:0] DAC_CODE,
    output logic [N_CH-1:0]           DAC_UPDATE,
    output logic                      BUSY
);

    localparam int FRAC_W = FLOAT_WIDTH - INT_WIDTH;
    localparam logic [FLOAT_WIDTH-1:0] GAIN_ONE = {{(FLOAT_WIDTH-1){1'b0}}, 1'b1} << FRAC_W;
    localparam int CNT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_LAT - 1);
    localparam logic [CH_W-1:0]  LAST_INIT = CH_W'(N_CH - 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CH_W-1:0]        sel_reg;
    logic [CH_W-1:0]        last_reg;
    logic [N_CH-1:0]        pend_reg, pend_next;
    logic                   req_ready_reg;

    logic [FLOAT_WIDTH-1:0] volt_reg [N_CH];
    logic [FLOAT_WIDTH-1:0] gain_reg [N_CH];
    logic [FLOAT_WIDTH-1:0] offset_reg [N_CH];
    logic [FLOAT_WIDTH-1:0] conv_volt_reg, conv_gain_reg, conv_offset_reg;
    logic [DAC_WIDTH-1:0]   dac_code_reg [N_CH];
    logic [N_CH-1:0]        dac_update_reg;

    logic                   pick_valid;
    logic [CH_W-1:0]        pick_ch;
    logic [CH_W-1:0]        cand;
    logic                   issue;
    logic                   capture;
    logic                   req_fire;

    // Channel index base+off modulo N_CH; off never exceeds N_CH.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) begin
            s = s - N_CH;
        end
        return s[CH_W-1:0];
    endfunction

    assign req_fire = REQ_VALID & req_ready_reg;
    assign issue    = (state_reg == IDLE) & ENABLE & pick_valid;
    assign capture  = (state_reg == CONV) & (cnt_reg == '0);

    // Round-robin pick: scan from farthest to nearest so the channel closest after LAST wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_ch    = '0;
        cand       = '0;
        for (int i = N_CH; i >= 1; i--) begin
            cand = wrap_add(last_reg, i);
            if (pend_reg[cand]) begin
                pick_valid = 1'b1;
                pick_ch    = cand;
            end
        end
    end

    // Next state: one issue leads to a CONV_LAT-cycle hold, then capture returns to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (issue)   state_next = CONV;
            CONV:    if (capture) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pending bits: clear on issue first, so a same-edge request or calibration re-sets it.
    always_comb begin
        pend_next = pend_reg;
        if (issue) begin
            pend_next[pick_ch] = 1'b0;
        end
        if (req_fire) begin
            pend_next[REQ_CH] = 1'b1;
        end
        if (CAL_WE) begin
            pend_next[CAL_CH] = 1'b1;
        end
    end

    // Control registers: state, hold counter, selected/last channel, pending, ready.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sel_reg       <= '0;
            last_reg      <= LAST_INIT;
            pend_reg      <= '0;
            req_ready_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_reg      <= pend_next;
            req_ready_reg <= 1'b1;
            if (issue) begin
                sel_reg <= pick_ch;
                cnt_reg <= CNT_LOAD;
            end else if ((state_reg == CONV) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (capture) begin
                last_reg <= sel_reg;
            end
        end
    end

    // Per-channel voltage and calibration tables.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N_CH; k++) begin
                volt_reg[k]   <= '0;
                gain_reg[k]   <= GAIN_ONE;
                offset_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (req_fire && (REQ_CH == CH_W'(k))) begin
                    volt_reg[k] <= REQ_VOLTAGE;
                end
                if (CAL_WE && (CAL_CH == CH_W'(k))) begin
                    gain_reg[k]   <= CAL_GAIN;
                    offset_reg[k] <= CAL_OFFSET;
                end
            end
        end
    end

    // Converter operands: loaded only on issue, frozen for the whole hold window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            conv_volt_reg   <= '0;
            conv_gain_reg   <= '0;
            conv_offset_reg <= '0;
        end else if (issue) begin
            conv_volt_reg   <= volt_reg[pick_ch];
            conv_gain_reg   <= gain_reg[pick_ch];
            conv_offset_reg <= offset_reg[pick_ch];
        end
    end

    // DAC output registers and one-cycle update strobe for the captured channel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < N_CH; k++) begin
                dac_code_reg[k] <= '0;
            end
            dac_update_reg <= '0;
        end else begin
            dac_update_reg <= '0;
            if (capture) begin
                dac_code_reg[sel_reg]   <= CONV_CODE;
                dac_update_reg[sel_reg] <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_dac_out
            assign DAC_CODE[gi*DAC_WIDTH +: DAC_WIDTH] = dac_code_reg[gi];
        end
    endgenerate

    assign CONV_VOLTAGE = conv_volt_reg;
    assign CONV_GAIN    = conv_gain_reg;
    assign CONV_OFFSET  = conv_offset_reg;
    assign DAC_UPDATE   = dac_update_reg;
    assign REQ_READY    = req_ready_reg;
    assign BUSY         = (state_reg == CONV) | (|pend_reg);

endmodule

// File: tb/tb_dac_update_sched.sv
// Testbench for dac_update_sched: directed table and sequences for the
// scheduling corner cases, then random traffic against an event-queue model.
module tb_dac_update_sched;

    localparam int FW   = 64;
    localparam int IW   = 16;
    localparam int DW   = 14;
    localparam int NCH  = 4;
    localparam int LAT  = 2;
    localparam int CW   = 2;
    localparam int FRAC = FW - IW;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            ENABLE = 1'b0;
    logic            REQ_VALID = 1'b0;
    logic [CW-1:0]   REQ_CH = '0;
    logic [FW-1:0]   REQ_VOLTAGE = '0;
    logic            REQ_READY;
    logic            CAL_WE = 1'b0;
    logic [CW-1:0]   CAL_CH = '0;
    logic [FW-1:0]   CAL_GAIN = '0;
    logic [FW-1:0]   CAL_OFFSET = '0;
    logic [FW-1:0]   CONV_VOLTAGE, CONV_GAIN, CONV_OFFSET;
    logic [DW-1:0]   CONV_CODE;
    logic [NCH*DW-1:0] DAC_CODE;
    logic [NCH-1:0]  DAC_UPDATE;
    logic            BUSY;

    always #5 CLK = ~CLK;

    // Bench converter: integer part of voltage plus integer part of offset.
    assign CONV_CODE = CONV_VOLTAGE[FRAC +: DW] + CONV_OFFSET[FRAC +: DW];

    dac_update_sched #(
        .FLOAT_WIDTH(FW), .INT_WIDTH(IW), .DAC_WIDTH(DW), .N_CH(NCH), .CONV_LAT(LAT)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
        .REQ_VALID(REQ_VALID), .REQ_CH(REQ_CH), .REQ_VOLTAGE(REQ_VOLTAGE), .REQ_READY(REQ_READY),
        .CAL_WE(CAL_WE), .CAL_CH(CAL_CH), .CAL_GAIN(CAL_GAIN), .CAL_OFFSET(CAL_OFFSET),
        .CONV_VOLTAGE(CONV_VOLTAGE), .CONV_GAIN(CONV_GAIN), .CONV_OFFSET(CONV_OFFSET),
        .CONV_CODE(CONV_CODE), .DAC_CODE(DAC_CODE), .DAC_UPDATE(DAC_UPDATE), .BUSY(BUSY)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cycle    = 0;
    int multi_hot = 0;
    int upd_ch[$];
    int upd_code[$];
    int upd_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] fx(input int v);
        return {v[15:0], 48'h0};
    endfunction

    function automatic int code_of(input int k);
        return int'(DAC_CODE[k*DW +: DW]);
    endfunction

    // One clock: sample 1 time unit after the edge and log any update strobes.
    task automatic step();
        @(posedge CLK);
        #1;
        cycle++;
        if (DAC_UPDATE != '0) begin
            if ($countones(DAC_UPDATE) != 1) multi_hot++;
            for (int k = 0; k < NCH; k++) begin
                if (DAC_UPDATE[k]) begin
                    upd_ch.push_back(k);
                    upd_code.push_back(code_of(k));
                    upd_cyc.push_back(cycle);
                    $display("cycle %0d: update ch%0d code %0d", cycle, k, code_of(k));
                end
            end
        end
    endtask

    task automatic clear_inputs();
        REQ_VALID = 1'b0; REQ_CH = '0; REQ_VOLTAGE = '0;
        CAL_WE = 1'b0; CAL_CH = '0; CAL_GAIN = fx(1); CAL_OFFSET = '0;
    endtask

    task automatic req_step(input int ch, input int v);
        clear_inputs();
        REQ_VALID = 1'b1; REQ_CH = CW'(ch); REQ_VOLTAGE = fx(v);
        step();
        clear_inputs();
    endtask

    task automatic idle_steps(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        upd_ch.delete(); upd_code.delete(); upd_cyc.delete();
        multi_hot = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        step();
        RST = 1'b0;
        step();
        clear_log();
    endtask

    // Run until the scheduler drains, bounded by max_cyc.
    task automatic collect(input string tag, input int max_cyc);
        int n;
        n = 0;
        clear_inputs();
        do begin
            step();
            n++;
        end while (BUSY && n < max_cyc);
        check({tag, "_drained"}, 64'(BUSY), 64'd0);
    endtask

    task automatic expect_updates(input string tag, input int exp_ch[4], input int exp_code[4], input int n);
        check({tag, "_count"}, 64'(upd_ch.size()), 64'(n));
        for (int i = 0; i < n && i < upd_ch.size(); i++) begin
            check($sformatf("%s_ch%0d", tag, i), 64'(upd_ch[i]), 64'(exp_ch[i]));
            check($sformatf("%s_code%0d", tag, i), 64'(upd_code[i]), 64'(exp_code[i]));
        end
        check({tag, "_onehot"}, 64'(multi_hot), 64'd0);
    endtask

    typedef struct {
        bit       rv;
        int       ch;
        int       v;
        logic [3:0] upd;
        int       conv_v;
        int       code2;
        bit       busy;
    } vec_t;

    // Reference model state (event-timestamp view of the scheduler)
    logic [63:0] m_volt [NCH];
    logic [63:0] m_off  [NCH];
    int          m_dac  [NCH];
    bit [NCH-1:0] m_pend;
    int          m_last;
    int          m_free;
    bit          m_ready;
    int          ev_cyc[$];
    int          ev_ch[$];
    int          ev_code[$];
    logic [NCH-1:0] m_upd;

    task automatic model_edge(input int c, input bit r_rst, input bit r_en, input bit r_rv, input int r_ch,
                              input logic [63:0] r_v, input bit r_cwe, input int r_cch, input logic [63:0] r_off);
        logic [DW-1:0] sum;
        int k;
        m_upd = '0;
        if (r_rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_volt[i] = '0; m_off[i] = '0; m_dac[i] = 0;
            end
            m_pend = '0; m_last = NCH - 1; m_free = c + 1; m_ready = 1'b0;
            ev_cyc.delete(); ev_ch.delete(); ev_code.delete();
        end else begin
            if (ev_cyc.size() > 0 && ev_cyc[0] == c) begin
                m_dac[ev_ch[0]] = ev_code[0];
                m_upd[ev_ch[0]] = 1'b1;
                m_last = ev_ch[0];
                void'(ev_cyc.pop_front()); void'(ev_ch.pop_front()); void'(ev_code.pop_front());
            end
            if (c >= m_free && r_en && m_pend != '0) begin
                k = -1;
                for (int off = 1; off <= NCH; off++) begin
                    if (k < 0 && m_pend[(m_last + off) % NCH]) k = (m_last + off) % NCH;
                end
                sum = m_volt[k][FRAC +: DW] + m_off[k][FRAC +: DW];
                ev_cyc.push_back(c + LAT); ev_ch.push_back(k); ev_code.push_back(int'(sum));
                m_pend[k] = 1'b0;
                m_free = c + LAT + 1;
            end
            if (r_rv && m_ready) begin
                m_volt[r_ch] = r_v; m_pend[r_ch] = 1'b1;
            end
            if (r_cwe) begin
                m_off[r_cch] = r_off; m_pend[r_cch] = 1'b1;
            end
            m_ready = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        logic [NCH*DW-1:0] exp_dac;
        bit r_rst, r_en, r_rv, r_cwe;
        int r_ch, r_cch;
        logic [63:0] r_v, r_off, r_gain;

        // Reset state
        clear_inputs();
        RST = 1'b1;
        ENABLE = 1'b1;
        step();
        check("rst_ready", 64'(REQ_READY), 64'd0);
        check("rst_dac_code", 64'(DAC_CODE), 64'd0);
        check("rst_dac_update", 64'(DAC_UPDATE), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_conv_v", CONV_VOLTAGE, 64'd0);
        check("rst_conv_g", CONV_GAIN, 64'd0);
        check("rst_conv_o", CONV_OFFSET, 64'd0);
        RST = 1'b0;
        step();
        check("rst_release_ready", 64'(REQ_READY), 64'd1);
        clear_log();

        // Test 1: single request, table-driven per cycle
        tbl[0] = '{1'b1, 2, 5, 4'b0000, 0, 0, 1'b1};
        tbl[1] = '{1'b0, 0, 0, 4'b0000, 5, 0, 1'b1};
        tbl[2] = '{1'b0, 0, 0, 4'b0000, 5, 0, 1'b1};
        tbl[3] = '{1'b0, 0, 0, 4'b0100, 5, 5, 1'b0};
        tbl[4] = '{1'b0, 0, 0, 4'b0000, 5, 5, 1'b0};
        for (int i = 0; i < 5; i++) begin
            clear_inputs();
            if (tbl[i].rv) begin
                REQ_VALID = 1'b1; REQ_CH = CW'(tbl[i].ch); REQ_VOLTAGE = fx(tbl[i].v);
            end
            step();
            check($sformatf("t1_upd_e%0d", i), 64'(DAC_UPDATE), 64'(tbl[i].upd));
            check($sformatf("t1_convv_e%0d", i), CONV_VOLTAGE, fx(tbl[i].conv_v));
            check($sformatf("t1_code2_e%0d", i), 64'(code_of(2)), 64'(tbl[i].code2));
            check($sformatf("t1_busy_e%0d", i), 64'(BUSY), 64'(tbl[i].busy));
        end
        check("t1_gain_default", CONV_GAIN, fx(1));
        check("t1_other_codes", 64'(code_of(0) + code_of(1) + code_of(3)), 64'd0);

        // Test 2: round robin starting at channel 0
        do_reset();
        ENABLE = 1'b0;
        req_step(3, 13); req_step(1, 11); req_step(0, 10); req_step(2, 12);
        check("t2_busy_pending", 64'(BUSY), 64'd1);
        ENABLE = 1'b1;
        collect("t2", 40);
        expect_updates("t2", '{0, 1, 2, 3}, '{10, 11, 12, 13}, 4);
        for (int i = 1; i < upd_cyc.size(); i++)
            check($sformatf("t2_spacing%0d", i), 64'(upd_cyc[i] - upd_cyc[i-1]), 64'(LAT + 1));

        // Test 3: coalescing and set-wins on the issue edge
        do_reset();
        ENABLE = 1'b1;
        req_step(0, 4);
        req_step(1, 7);
        req_step(1, 9);
        idle_steps(1);
        req_step(1, 11);
        check("t3_conv_old_value", CONV_VOLTAGE, fx(9));
        check("t3_busy", 64'(BUSY), 64'd1);
        collect("t3", 40);
        expect_updates("t3", '{0, 1, 1, 0}, '{4, 9, 11, 0}, 3);

        // Test 4: calibration write during conversion
        do_reset();
        ENABLE = 1'b1;
        req_step(0, 3);
        idle_steps(1);
        clear_inputs();
        CAL_WE = 1'b1; CAL_CH = 2'd0; CAL_GAIN = fx(1); CAL_OFFSET = fx(2);
        step();
        clear_inputs();
        collect("t4", 40);
        expect_updates("t4", '{0, 0, 0, 0}, '{3, 5, 0, 0}, 2);

        // Test 5: reset in the middle of a conversion
        do_reset();
        ENABLE = 1'b1;
        req_step(1, 8);
        collect("t5_pre", 20);
        check("t5_pre_code", 64'(code_of(1)), 64'd8);
        clear_log();
        req_step(2, 6);
        idle_steps(1);
        RST = 1'b1;
        step();
        check("t5_rst_update", 64'(DAC_UPDATE), 64'd0);
        check("t5_rst_codes", 64'(DAC_CODE), 64'd0);
        check("t5_rst_ready", 64'(REQ_READY), 64'd0);
        check("t5_rst_busy", 64'(BUSY), 64'd0);
        RST = 1'b0;
        step();
        check("t5_ready_after", 64'(REQ_READY), 64'd1);
        idle_steps(5);
        check("t5_no_updates", 64'(upd_ch.size()), 64'd0);
        check("t5_codes_zero", 64'(DAC_CODE), 64'd0);

        // Test 6: ENABLE gating
        do_reset();
        ENABLE = 1'b0;
        req_step(1, 5);
        req_step(2, 6);
        idle_steps(3);
        check("t6_busy_blocked", 64'(BUSY), 64'd1);
        check("t6_no_issue", CONV_VOLTAGE, 64'd0);
        check("t6_no_update", 64'(upd_ch.size()), 64'd0);
        ENABLE = 1'b1;
        step();
        ENABLE = 1'b0;
        idle_steps(6);
        check("t6_inflight_code", 64'(code_of(1)), 64'd5);
        check("t6_held_code", 64'(code_of(2)), 64'd0);
        check("t6_still_busy", 64'(BUSY), 64'd1);
        ENABLE = 1'b1;
        collect("t6", 30);
        expect_updates("t6", '{1, 2, 0, 0}, '{5, 6, 0, 0}, 2);

        // Random traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            r_rst  = (c == 0) || ($urandom_range(99) == 0);
            r_en   = ($urandom_range(9) < 8);
            r_rv   = ($urandom_range(9) < 4);
            r_ch   = int'($urandom_range(NCH - 1));
            r_v    = {$urandom, $urandom};
            r_cwe  = ($urandom_range(9) < 1);
            r_cch  = int'($urandom_range(NCH - 1));
            r_off  = {$urandom, $urandom};
            r_gain = {$urandom, $urandom};
            RST = r_rst; ENABLE = r_en;
            REQ_VALID = r_rv; REQ_CH = CW'(r_ch); REQ_VOLTAGE = r_v;
            CAL_WE = r_cwe; CAL_CH = CW'(r_cch); CAL_OFFSET = r_off; CAL_GAIN = r_gain;
            model_edge(c, r_rst, r_en, r_rv, r_ch, r_v, r_cwe, r_cch, r_off);
            step();
            for (int k = 0; k < NCH; k++) exp_dac[k*DW +: DW] = DW'(m_dac[k]);
            check($sformatf("rand_upd_c%0d", c), 64'(DAC_UPDATE), 64'(m_upd));
            check($sformatf("rand_dac_c%0d", c), 64'(DAC_CODE), 64'(exp_dac));
            check($sformatf("rand_busy_c%0d", c), 64'(BUSY), 64'((ev_cyc.size() > 0) || (m_pend != '0)));
            check($sformatf("rand_ready_c%0d", c), 64'(REQ_READY), 64'(m_ready));
        end
        RST = 1'b0;
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_update_sched.md
# dac_update_sched

Sequencer that shares one DAC calibration/conversion datapath (gain multiply, offset subtract, volts-to-code scale) among N_CH DAC channels of the SPGD controller. It latches per-channel voltage requests and per-channel calibration constants, issues pending channels to the shared converter in round-robin order, and holds the converter inputs stable for a fixed multicycle latency. It then captures the resulting code into that channel's DAC output register and pulses a per-channel update strobe.

## Interface
- FLOAT_WIDTH, 64: width of fixed-point voltage/gain/offset words, Q(INT_WIDTH).(FLOAT_WIDTH-INT_WIDTH).
- INT_WIDTH, 16: integer bits of the fixed-point format.
- DAC_WIDTH, 14: DAC code width.
- N_CH, 4: number of DAC channels (≥2).
- CONV_LAT, 2: cycles the converter inputs are held before the code is sampled (≥1).
- CH_W, $clog2(N_CH): channel index width (localparam).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- ENABLE  in  1  permits issuing new conversions.
- REQ_VALID  in  1  voltage request strobe.
- REQ_CH  in  CH_W  target channel.
- REQ_VOLTAGE  in  FLOAT_WIDTH  requested voltage.
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY.
- CAL_WE  in  1  calibration write strobe.
- CAL_CH  in  CH_W  channel being calibrated.
- CAL_GAIN  in  FLOAT_WIDTH  gain constant.
- CAL_OFFSET  in  FLOAT_WIDTH  offset constant.
- CONV_VOLTAGE  out  FLOAT_WIDTH  converter voltage input, registered.
- CONV_GAIN  out  FLOAT_WIDTH  converter gain input, registered.
- CONV_OFFSET  out  FLOAT_WIDTH  converter offset input, registered.
- CONV_CODE  in  DAC_WIDTH  converter result, combinational from CONV_*.
- DAC_CODE  out  N_CH*DAC_WIDTH  output codes, channel k at [k*DAC_WIDTH +: DAC_WIDTH].
- DAC_UPDATE  out  N_CH  one-cycle strobe, bit k when DAC_CODE of channel k changes.
- BUSY  out  1  conversion in flight or any channel pending.

## Operation
- Per-channel storage: voltage latch VOLT[k], GAIN[k], OFFSET[k], and pending bit PEND[k].
- Accepted request: VOLT[REQ_CH] <= REQ_VOLTAGE and PEND[REQ_CH] <= 1. A second request to an already-pending channel overwrites the value; only the latest value is converted (coalescing).
- CAL_WE: GAIN[CAL_CH] and OFFSET[CAL_CH] are written and PEND[CAL_CH] <= 1, so the channel is reconverted with the new constants. CAL_WE and REQ_VALID are independent and may occur in the same cycle, including on the same channel.
- FSM states:
  - IDLE: if ENABLE and any PEND is set, select the first pending channel searching from LAST+1 upward, with wrap-around. On that edge: latch CONV_* from that channel's tables, clear its PEND, record SEL, load the counter with CONV_LAT-1, and go to CONV. Otherwise stay in IDLE.
  - CONV: CONV_* are frozen. The counter decrements each cycle. When the counter is 0, on that edge: DAC_CODE[SEL] <= CONV_CODE, DAC_UPDATE[SEL] <= 1 for one cycle, LAST <= SEL, go to IDLE.
- Set wins over clear: if a request or calibration write targets the channel being issued on the same edge, PEND stays 1. CONV_* carry the pre-write values. The channel is reconverted later.
- Table writes during CONV never disturb CONV_* or the in-flight result.
- ENABLE low blocks new issues only. An in-flight conversion completes normally.
- REQ_READY is registered: 0 in the cycle after RST is asserted, and 1 from the first cycle after RST is released.
- BUSY = (state==CONV) | (|PEND), combinational.
- Reset values:
  - State IDLE, PEND=0, LAST=N_CH-1 so channel 0 is served first.
  - VOLT=0, GAIN=1.0 (1 << (FLOAT_WIDTH-INT_WIDTH)), OFFSET=0.
  - CONV_*=0, DAC_CODE=0, DAC_UPDATE=0, REQ_READY=0.
- Reset mid-conversion aborts it: no capture, no DAC_UPDATE, DAC_CODE returns to 0.

## Timing
- Request sampled at edge 0 → issue at edge 1 → capture at edge 1+CONV_LAT. DAC_UPDATE is high in the cycle following the capture edge.
- Converter inputs are stable for exactly CONV_LAT cycles before sampling. The converter path is a CONV_LAT-cycle multicycle path.
- Back-to-back issue period is CONV_LAT+1 cycles per channel. The earliest next issue is edge 2+CONV_LAT.
- At most one DAC_UPDATE bit is high in any cycle.

## Test plan
Bench converter model: CONV_CODE = CONV_VOLTAGE[FLOAT_WIDTH-INT_WIDTH +: DAC_WIDTH] + CONV_OFFSET[FLOAT_WIDTH-INT_WIDTH +: DAC_WIDTH]. CONV_LAT=2, N_CH=4.
1. Single request: after reset, REQ ch2 = 5.0 at edge 0 → CONV_VOLTAGE=0x0005_0000_0000_0000 from edge 1; capture at edge 3 gives DAC_CODE ch2 = 5; DAC_UPDATE=4'b0100 for one cycle; BUSY low after edge 3.
2. Round robin: requests to ch3, ch1, ch0, ch2 in consecutive cycles → updates occur in order ch0, ch1, ch2, ch3 (LAST starts at 3), 3 cycles apart, codes match the requested integers.
3. Coalescing and set-wins: ch1=7.0 while ch0 is converting, then ch1=9.0 → exactly one ch1 update with code 9. A ch1=11.0 request on ch1's own issue edge → ch1 is converted again later, final code 11.
4. Calibration mid-conversion: during ch0 conversion of 3.0, write CAL ch0 offset=2.0 → first update code 3, second update code 5.
5. Reset mid-conversion: RST asserted one cycle after issue → no DAC_UPDATE, all DAC_CODE=0, REQ_READY=0 for that cycle, 1 after release.
6. ENABLE gating: ENABLE=0 with ch1 pending → no issue, BUSY=1; ENABLE drop during CONV → in-flight update still occurs; ENABLE=1 → remaining pending channels resume.
